// File: rtl/nx_fifo_pop_stage_if.sv
// rtl/nx_fifo_pop_stage_if.sv - valid/ready output stream of the FIFO pop stage
interface nx_fifo_pop_stage_if #(
    parameter int WIDTH = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/nx_fifo_pop_stage.sv
// rtl/nx_fifo_pop_stage.sv - FIFO pop stage with 2-entry skid, flush sequencing and sticky errors
// Optional out_count statistics counter under NX_FIFO_POP_STATS_EN.
module nx_fifo_pop_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fifo_empty,
    input  logic [WIDTH-1:0]   fifo_rdata,
    input  logic               fifo_underflow,
    input  logic               fifo_overflow,
    output logic               fifo_ren,
    output logic               fifo_clear,
    input  logic               flush,
    output logic               flush_busy,
    output logic               err_underflow,
    output logic               err_overflow,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   out_count,
    nx_fifo_pop_stage_if.master out_if
);

    typedef enum logic [1:0] {
        ST_S0    = 2'd0,
        ST_S1    = 2'd1,
        ST_S2    = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] h_q, h_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             err_uf_q, err_uf_d;
    logic             err_of_q, err_of_d;
    logic             valid;
    logic             pop;
    logic             push;

    assign valid = (state_q == ST_S1) || (state_q == ST_S2);
    assign pop   = valid & out_if.out_ready;

    // Read strobe looks only at registered state, never at out_ready.
    assign push = rst_n & !fifo_empty & !flush &
                  ((state_q == ST_S0) || (state_q == ST_S1));

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        s_d        = s_q;
        fifo_clear = 1'b0;
        flush_busy = 1'b0;
        unique case (state_q)
            ST_S0: begin
                if (push) begin
                    state_d = ST_S1;
                    h_d     = fifo_rdata;
                end
            end
            ST_S1: begin
                if (push && !pop) begin
                    state_d = ST_S2;
                    s_d     = fifo_rdata;
                end else if (push && pop) begin
                    h_d = fifo_rdata;
                end else if (pop) begin
                    state_d = ST_S0;
                end
            end
            ST_S2: begin
                if (pop) begin
                    state_d = ST_S1;
                    h_d     = s_q;
                end
            end
            ST_FLUSH: begin
                fifo_clear = 1'b1;
                flush_busy = 1'b1;
                state_d    = ST_S0;
                h_d        = '0;
                s_d        = '0;
            end
            default: state_d = ST_S0;
        endcase
        // A pop coinciding with the flush request still completes on this edge.
        if (flush && (state_q != ST_FLUSH)) begin
            state_d = ST_FLUSH;
        end
    end

    always_comb begin
        err_uf_d = (err_uf_q & !err_clr) | fifo_underflow;
        err_of_d = (err_of_q & !err_clr) | fifo_overflow;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_S0;
            h_q      <= '0;
            s_q      <= '0;
            err_uf_q <= 1'b0;
            err_of_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            s_q      <= s_d;
            err_uf_q <= err_uf_d;
            err_of_q <= err_of_d;
        end
    end

    assign fifo_ren         = push;
    assign out_if.out_valid = valid;
    assign out_if.out_data  = h_q;
    assign err_underflow    = err_uf_q;
    assign err_overflow     = err_of_q;

`ifdef NX_FIFO_POP_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(pop);
        if (state_q == ST_FLUSH) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_count = cnt_q;
`else
    assign out_count = '0;
`endif

endmodule
